seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Drives a 3-digit multiplexed common-cathode 7-segment display from an 8-bit value, for example a byte received by the UART receiver.
- Converts the byte to BCD with a sequential double-dabble FSM, one iteration per clock.
- Time-multiplexes the three digits through one shared instance of the team's binary_to_7seg decoder.
- Sits between the UART RX data/valid strobe and the board's segment and digit-enable pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled; legal range >= 2.
- DIGIT_ACTIVE_LOW, 0: 1 inverts digit_en at the output register (for PNP digit drivers); segments are always active-high.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- data_in  input  8  binary value to display.
- data_valid  input  1  one-cycle strobe; data_in is sampled when data_valid=1 and busy=0.
- busy  output  1  conversion in progress; data_valid is ignored while high.
- seg_out  output  7  segment pattern {g,f,e,d,c,b,a}, active-high, registered.
- digit_en  output  3  one-hot digit enable; bit0=units, bit1=tens, bit2=hundreds; registered.

Behaviour:
- Reset, synchronous and active-high:
  - busy=0; FSM=IDLE.
  - Display registers hundreds/tens/units = 0.
  - Prescaler = 0; scan index = 0.
  - seg_out=7'b0111111; digit_en=3'b001 (inverted if DIGIT_ACTIVE_LOW).
- Reset asserted mid-conversion aborts the conversion. Display returns to 0 on the cycle after reset deasserts.
- Conversion FSM states:
  - IDLE: data_valid=1 captures data_in into the shift register, clears the 12-bit BCD accumulator and iteration count, and moves to CONV.
  - CONV: each cycle, every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1. After the 8th iteration the FSM moves to LOAD.
  - LOAD: the accumulator is copied into the display registers in one cycle, and the FSM returns to IDLE.
- Conversion timing:
  - busy=1 from the cycle after acceptance through the LOAD cycle inclusive, 9 cycles total.
  - busy=0 in the IDLE cycle that accepts.
  - data_valid during busy is dropped; there is no queueing and no error flag.
  - data_valid in the same cycle busy falls (first IDLE cycle) is accepted.
- BCD digits are always 0..9; decoder codes 10..15 are never presented.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count the scan index advances 0->1->2->0; index 3 is unreachable and, if forced, recovers to 0.
- Output register, loaded every cycle:
  - seg_out <= decode(display[index]) via the shared decoder; digit_en <= onehot(index).
  - Both outputs update on the same edge, so a digit is never enabled with another digit's pattern.
  - Outputs lag index and display changes by 1 cycle.
- A display update during a scan slot takes effect 1 cycle after LOAD, without waiting for the slot boundary.
- Exactly one digit_en bit is active in every cycle after reset.

Optional Feature:
- Macro SEG_SCAN_BLANKING_EN enables leading-zero blanking.
- With the macro:
  - Hundreds digit blanked (seg_out=7'b0000000) when it is 0.
  - Tens digit blanked when both hundreds and tens are 0.
  - Units digit never blanked.
  - digit_en keeps scanning normally.
- Without the macro: all three digits always show their decoded value, including leading 0 patterns (7'b0111111).

Test Plan:
- Reset with REFRESH_DIV=4: hold rst 3 cycles, release -> busy=0, digit_en=001, seg_out=0111111. digit_en then follows 001,010,100,001 at 4-cycle intervals with exactly one bit set.
- data_in=173 with a data_valid pulse -> busy high exactly 9 cycles. Then the units slot shows 1001111 (3), tens 0000111 (7), hundreds 0000110 (1).
- data_in=5:
  - With SEG_SCAN_BLANKING_EN: hundreds and tens seg_out=0000000, units 1101101.
  - Without the macro: hundreds and tens 0111111.
  - data_in=200 with the macro: tens shows 0111111 (not blanked).
- Send 200, then data_valid with 42 two cycles later -> 42 ignored, display 2,0,0. Send 42 on the first cycle busy=0 -> accepted, display 0/blank,4,2.
- Boundaries: data_in=255 -> 2,5,5 (1011011,1101101,1101101); data_in=0 -> units 0111111.
- Assert rst during CONV cycle 4 of a 99 conversion -> busy=0 next cycle, display remains 0, and the next valid strobe is accepted normally.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Byte-to-3-digit 7-segment scanner: double-dabble BCD conversion plus a time-multiplexed output register.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_BLANKING_EN.

module binary_to_7seg (
  input  logic [3:0] bin_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bin_i)
      4'd0:    seg_o = 7'b0111111;
      4'd1:    seg_o = 7'b0000110;
      4'd2:    seg_o = 7'b1011011;
      4'd3:    seg_o = 7'b1001111;
      4'd4:    seg_o = 7'b1100110;
      4'd5:    seg_o = 7'b1101101;
      4'd6:    seg_o = 7'b1111101;
      4'd7:    seg_o = 7'b0000111;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1101111;
      4'd10:   seg_o = 7'b1110111;
      4'd11:   seg_o = 7'b1111100;
      4'd12:   seg_o = 7'b0111001;
      4'd13:   seg_o = 7'b1011110;
      4'd14:   seg_o = 7'b1111001;
      default: seg_o = 7'b1110001;
    endcase
  end
endmodule

module seg_scan_controller #(
  parameter int REFRESH_DIV      = 50000,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       busy,
  output logic [6:0] seg_out,
  output logic [2:0] digit_en
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [2:0] EN_RST = DIGIT_ACTIVE_LOW ? 3'b110 : 3'b001;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [11:0]     bcd_q, bcd_d, bcd_adj;
  logic [2:0]      iter_q, iter_d;
  logic [11:0]     disp_q, disp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d, dec_seg;
  logic [2:0]      en_q, en_d, onehot;
  logic [3:0]      digit;
  logic [19:0]     dabble;
  logic            blank;

  assign busy     = (state_q != IDLE);
  assign seg_out  = seg_q;
  assign digit_en = en_q;

  always_comb begin
    for (int n = 0; n < 3; n++)
      bcd_adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3 : bcd_q[n*4 +: 4];
  end
  assign dabble = {bcd_adj[10:0], shift_q, 1'b0};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: if (data_valid) begin
        shift_d = data_in;
        bcd_d   = '0;
        iter_d  = '0;
        state_d = CONV;
      end
      CONV: begin
        bcd_d   = dabble[19:8];
        shift_d = dabble[7:0];
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index 3 is never produced; treating it like 2 makes a corrupted index fall back to units.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd1:    begin digit = disp_q[7:4];  onehot = 3'b010; end
      2'd2:    begin digit = disp_q[11:8]; onehot = 3'b100; end
      default: begin digit = disp_q[3:0];  onehot = 3'b001; end
    endcase
`ifdef SEG_SCAN_BLANKING_EN
    blank = ((idx_q == 2'd2) && (disp_q[11:8] == 4'd0)) ||
            ((idx_q == 2'd1) && (disp_q[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 7'b0000000 : dec_seg;
    en_d  = DIGIT_ACTIVE_LOW ? ~onehot : onehot;
  end

  binary_to_7seg u_dec (
    .bin_i (digit),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b0111111;
      en_q    <= EN_RST;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed + random bytes against a value-level display model.
module tb_seg_scan_controller;
  localparam int DIV = 4;

  logic       clk, rst, data_valid;
  logic [7:0] data_in;
  logic       busy;
  logic [6:0] seg_out;
  logic [2:0] digit_en;

  int checks = 0, failures = 0;
  int k, conv_left, conv_val, pend, pend_val, shown;

  logic [6:0] SEGT [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  seg_scan_controller #(.REFRESH_DIV(DIV), .DIGIT_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .busy(busy), .seg_out(seg_out), .digit_en(digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outputs();
    int d, h, t, u, v;
    logic [6:0] exp_seg;
    logic [2:0] exp_en;
    logic       exp_busy;
    d = (k == 0) ? 0 : ((k - 1) / DIV) % 3;
    h = shown / 100;
    t = (shown / 10) % 10;
    u = shown % 10;
    v = (d == 0) ? u : (d == 1) ? t : h;
    exp_seg = SEGT[v];
`ifdef SEG_SCAN_BLANKING_EN
    if ((d == 2 && h == 0) || (d == 1 && h == 0 && t == 0)) exp_seg = 7'b0000000;
`endif
    exp_en   = 3'(1 << d);
    exp_busy = (conv_left > 0);
    checks++;
    assert (busy === exp_busy) else begin
      failures++; $error("FAIL busy k=%0d got=%b exp=%b", k, busy, exp_busy);
    end
    checks++;
    assert (digit_en === exp_en) else begin
      failures++; $error("FAIL digit_en k=%0d got=%b exp=%b", k, digit_en, exp_en);
    end
    checks++;
    assert (seg_out === exp_seg) else begin
      failures++; $error("FAIL seg_out k=%0d val=%0d digit=%0d got=%b exp=%b", k, shown, d, seg_out, exp_seg);
    end
    checks++;
    assert ($countones(digit_en) == 1) else begin
      failures++; $error("FAIL onehot k=%0d got=%b exp=one bit set", k, digit_en);
    end
  endtask

  // Model: a byte accepted on edge A is converted for 9 cycles, loaded on edge A+9, visible from edge A+10.
  task automatic tick();
    bit r, v;
    int d;
    r = rst; v = data_valid; d = data_in;
    @(posedge clk); #1;
    if (r) begin
      k = 0; conv_left = 0; pend = 0; shown = 0;
    end else begin
      k++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) shown = pend_val;
      end
      if (conv_left > 0) begin
        conv_left--;
        if (conv_left == 0) begin pend = 1; pend_val = conv_val; end
      end else if (v) begin
        conv_left = 9; conv_val = d;
      end
    end
    check_outputs();
  endtask

  task automatic send(input int v);
    data_in = 8'(v); data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic show_all();
    repeat (10 + 3 * DIV + 2) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    assert (n < 20) else begin
      failures++; $error("FAIL wait_idle timeout got=busy exp=idle within 20 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = 8'd0;
    k = 0; conv_left = 0; conv_val = 0; pend = 0; pend_val = 0; shown = 0;
    repeat (3) tick();
    checks++;
    assert (seg_out === 7'b0111111 && digit_en === 3'b001 && busy === 1'b0) else begin
      failures++; $error("FAIL reset_state got=%b/%b/%b exp=0111111/001/0", seg_out, digit_en, busy);
    end
    rst = 1'b0;
    repeat (14) tick();

    send(173); show_all();
    send(5);   show_all();
    send(200); show_all();
    send(255); show_all();
    send(0);   show_all();

    // Strobe during busy is dropped; a strobe on the first idle cycle is taken.
    send(200);
    tick();
    data_in = 8'd42; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_idle();
    send(42); show_all();

    send(99);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    assert (busy === 1'b0) else begin
      failures++; $error("FAIL abort_busy got=%b exp=0", busy);
    end
    repeat (3 * DIV + 1) tick();
    send(99); show_all();

    for (int i = 0; i < 25; i++) begin
      send($urandom_range(0, 255));
      repeat ($urandom_range(0, 12)) begin
        data_in = 8'($urandom);
        data_valid = 1'($urandom_range(0, 1));
        tick();
      end
      data_valid = 1'b0;
      if (i % 3 == 0) show_all();
    end
    wait_idle();
    show_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
